// File: rtl/sw_pe_affine_if.sv
// Bundle for one sw_pe_affine PE: query load, left-side inputs, scoring constants and right-side outputs.
// The pos_in/pos_out pair exists only when SW_PE_POS_TRACK_EN is defined.
interface sw_pe_affine_if #(
   parameter int SCORE_WIDTH = 12,
   parameter int BASE_WIDTH  = 2,
   parameter int POS_WIDTH   = 16
);
   logic                          query_ld;
   logic [BASE_WIDTH-1:0]         query_in;
   logic                          vld_in;
   logic                          last_in;
   logic [BASE_WIDTH-1:0]         data_in;
   logic signed [SCORE_WIDTH-1:0] H_in;
   logic signed [SCORE_WIDTH-1:0] E_in;
   logic signed [SCORE_WIDTH-1:0] max_in;
   logic signed [SCORE_WIDTH-1:0] match;
   logic signed [SCORE_WIDTH-1:0] mismatch;
   logic signed [SCORE_WIDTH-1:0] gap_open;
   logic signed [SCORE_WIDTH-1:0] gap_extend;
   logic                          vld_out;
   logic                          last_out;
   logic [BASE_WIDTH-1:0]         data_out;
   logic signed [SCORE_WIDTH-1:0] H_out;
   logic signed [SCORE_WIDTH-1:0] E_out;
   logic signed [SCORE_WIDTH-1:0] max_out;
   logic                          busy;
   logic                          done;

`ifdef SW_PE_POS_TRACK_EN
   logic [POS_WIDTH-1:0]          pos_in;
   logic [POS_WIDTH-1:0]          pos_out;

   modport master (
      output query_ld, query_in, vld_in, last_in, data_in, H_in, E_in, max_in, pos_in,
             match, mismatch, gap_open, gap_extend,
      input  vld_out, last_out, data_out, H_out, E_out, max_out, pos_out, busy, done
   );
   modport slave (
      input  query_ld, query_in, vld_in, last_in, data_in, H_in, E_in, max_in, pos_in,
             match, mismatch, gap_open, gap_extend,
      output vld_out, last_out, data_out, H_out, E_out, max_out, pos_out, busy, done
   );
`else
   // POS_WIDTH stays in the parameter list so both builds instantiate identically.
   if (POS_WIDTH < 1) begin : g_pos_width_unused
   end

   modport master (
      output query_ld, query_in, vld_in, last_in, data_in, H_in, E_in, max_in,
             match, mismatch, gap_open, gap_extend,
      input  vld_out, last_out, data_out, H_out, E_out, max_out, busy, done
   );
   modport slave (
      input  query_ld, query_in, vld_in, last_in, data_in, H_in, E_in, max_in,
             match, mismatch, gap_open, gap_extend,
      output vld_out, last_out, data_out, H_out, E_out, max_out, busy, done
   );
`endif
endinterface

// File: rtl/sw_pe_affine.sv
// Affine-gap Smith-Waterman processing element: holds one query symbol, computes one cell per valid target symbol.
// Optional macro SW_PE_POS_TRACK_EN adds pos_in/pos_out and a per-target position counter.
module sw_pe_affine #(
   parameter int SCORE_WIDTH = 12,
   parameter int BASE_WIDTH  = 2,
   parameter int POS_WIDTH   = 16
) (
   input  logic          clk,
   input  logic          rst,
   sw_pe_affine_if.slave pe
);
   typedef logic signed [SCORE_WIDTH-1:0] score_t;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam score_t NEG_INF = {1'b1, {(SCORE_WIDTH-1){1'b0}}};
   localparam score_t SAT_MAX = {1'b0, {(SCORE_WIDTH-1){1'b1}}};

   // One guard bit catches overflow; the guard and sign disagreeing means out of range.
   function automatic score_t sat_addsub(input score_t a, input score_t b, input logic sub);
      logic [SCORE_WIDTH:0] ax;
      logic [SCORE_WIDTH:0] bx;
      logic [SCORE_WIDTH:0] r;
      ax = {a[SCORE_WIDTH-1], a};
      bx = {b[SCORE_WIDTH-1], b};
      r  = sub ? (ax - bx) : (ax + bx);
      if (r[SCORE_WIDTH] != r[SCORE_WIDTH-1])
         return r[SCORE_WIDTH] ? NEG_INF : SAT_MAX;
      return score_t'(r[SCORE_WIDTH-1:0]);
   endfunction

   function automatic score_t smax(input score_t a, input score_t b);
      return (a > b) ? a : b;
   endfunction

   state_t                state_reg;
   logic                  busy_reg;
   logic                  done_reg;
   logic [BASE_WIDTH-1:0] query_reg;
   score_t                h_diag_reg;
   score_t                h_up_reg;
   score_t                f_up_reg;
   logic                  vld_out_reg;
   logic                  last_out_reg;
   logic [BASE_WIDTH-1:0] data_out_reg;
   score_t                h_out_reg;
   score_t                e_out_reg;
   score_t                max_out_reg;

   logic   in_run;
   logic   accept;
   logic   take_h;
   score_t h_diag_cur;
   score_t h_up_cur;
   score_t f_up_cur;
   score_t s_cur;
   score_t e_next;
   score_t f_next;
   score_t h_next;

   // Outside RUN the next accepted symbol starts a fresh target, so history reads as its initial values.
   assign in_run     = (state_reg == RUN);
   assign accept     = pe.vld_in && (state_reg != DONE);
   assign h_diag_cur = in_run ? h_diag_reg : '0;
   assign h_up_cur   = in_run ? h_up_reg : '0;
   assign f_up_cur   = in_run ? f_up_reg : NEG_INF;
   assign s_cur      = (pe.data_in == query_reg) ? pe.match : pe.mismatch;
   assign e_next     = smax(sat_addsub(pe.H_in, pe.gap_open, 1'b1), sat_addsub(pe.E_in, pe.gap_extend, 1'b1));
   assign f_next     = smax(sat_addsub(h_up_cur, pe.gap_open, 1'b1), sat_addsub(f_up_cur, pe.gap_extend, 1'b1));
   assign h_next     = smax(smax('0, sat_addsub(h_diag_cur, s_cur, 1'b0)), smax(e_next, f_next));
   assign take_h     = (h_next > pe.max_in);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg <= IDLE;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (pe.vld_in && pe.last_in) begin
                  state_reg <= DONE;
                  done_reg  <= 1'b1;
               end else if (pe.vld_in) begin
                  state_reg <= RUN;
                  busy_reg  <= 1'b1;
               end
            end
            RUN: begin
               if (pe.vld_in && pe.last_in) begin
                  state_reg <= DONE;
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b1;
               end
            end
            default: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
               done_reg  <= 1'b0;
            end
         endcase
      end
   end

   // Symbols arriving during the single DONE cycle are dropped.
   always_ff @(posedge clk) begin
      if (!rst) begin
         query_reg    <= '0;
         h_diag_reg   <= '0;
         h_up_reg     <= '0;
         f_up_reg     <= NEG_INF;
         vld_out_reg  <= 1'b0;
         last_out_reg <= 1'b0;
         data_out_reg <= '0;
         h_out_reg    <= '0;
         e_out_reg    <= NEG_INF;
         max_out_reg  <= '0;
      end else begin
         vld_out_reg <= accept;
         if ((state_reg == IDLE) && pe.query_ld)
            query_reg <= pe.query_in;
         if (accept) begin
            h_diag_reg   <= pe.H_in;
            h_up_reg     <= h_next;
            f_up_reg     <= f_next;
            last_out_reg <= pe.last_in;
            data_out_reg <= pe.data_in;
            h_out_reg    <= h_next;
            e_out_reg    <= e_next;
            max_out_reg  <= take_h ? h_next : pe.max_in;
         end
      end
   end

`ifdef SW_PE_POS_TRACK_EN
   logic [POS_WIDTH-1:0] cnt_reg;
   logic [POS_WIDTH-1:0] cnt_cur;
   logic [POS_WIDTH-1:0] pos_out_reg;

   assign cnt_cur = in_run ? cnt_reg : '0;

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_reg     <= '0;
         pos_out_reg <= '0;
      end else if (accept) begin
         cnt_reg     <= cnt_cur + 1'b1;
         pos_out_reg <= take_h ? cnt_cur : pe.pos_in;
      end else if (!in_run) begin
         cnt_reg <= '0;
      end
   end

   assign pe.pos_out = pos_out_reg;
`else
   // POS_WIDTH stays in the parameter list so both builds instantiate identically.
   if (POS_WIDTH < 1) begin : g_pos_width_unused
   end
`endif

   assign pe.vld_out  = vld_out_reg;
   assign pe.last_out = last_out_reg;
   assign pe.data_out = data_out_reg;
   assign pe.H_out    = h_out_reg;
   assign pe.E_out    = e_out_reg;
   assign pe.max_out  = max_out_reg;
   assign pe.busy     = busy_reg;
   assign pe.done     = done_reg;
endmodule
